// File: rtl/mmult_pkg.sv
// Shared types and sizing helpers for the systolic-array stream controller.
package mmult_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_N     = 4;

    typedef enum logic [1:0] {
        ST_LOAD_W  = 2'd0,
        ST_LOAD_A  = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_SEND    = 2'd3
    } state_t;

    function automatic int cnt_w(input int n);
        return (n * n > 1) ? $clog2(n * n) : 1;
    endfunction

endpackage

// File: rtl/mmult_out_ser.sv
// Captures one column-result vector and plays it out as an AXI-Stream packet.
module mmult_out_ser
    import mmult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [N*WIDTH-1:0] y_i,
    output logic [WIDTH-1:0]   tdata_o,
    output logic               tvalid_o,
    input  logic               tready_i,
    output logic               tlast_o,
    output logic               done_o
);

    localparam int JW = (N > 1) ? $clog2(N) : 1;

    logic [N*WIDTH-1:0] y_q;
    logic [JW-1:0]      j_q;
    logic [WIDTH-1:0]   tdata_q;
    logic               tvalid_q;
    logic               tlast_q;
    logic               m_hs;
    logic               j_last;

    assign m_hs   = tvalid_q && tready_i;
    assign j_last = (j_q == JW'(N - 1));

    // Output word and flags are registered so they stay frozen under backpressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            y_q      <= '0;
            j_q      <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (load_i) begin
            y_q      <= y_i;
            j_q      <= '0;
            tdata_q  <= y_i[WIDTH-1:0];
            tvalid_q <= 1'b1;
            tlast_q  <= (N == 1);
        end else if (m_hs) begin
            if (j_last) begin
                j_q      <= '0;
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end else begin
                j_q     <= j_q + 1'b1;
                tdata_q <= y_q[(int'(j_q) + 1) * WIDTH +: WIDTH];
                tlast_q <= ((int'(j_q) + 1) == (N - 1));
            end
        end
    end

    assign tdata_o  = tdata_q;
    assign tvalid_o = tvalid_q;
    assign tlast_o  = tlast_q;
    assign done_o   = m_hs && j_last;

endmodule

// File: rtl/mmult_axis_ctrl.sv
// AXI-Stream front end for an external combinational N x N weight-stationary array:
// loads weights and input vectors, drives the array, and streams column results back.
module mmult_axis_ctrl
    import mmult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [WIDTH-1:0]     s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 s_axis_tlast,
    output logic [WIDTH-1:0]     m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    input  logic                 reload_w,
    output logic [N*WIDTH-1:0]   a_vec,
    output logic [N*N*WIDTH-1:0] b_mat,
    input  logic [N*WIDTH-1:0]   y_vec,
    output logic                 err_tlast
);

    localparam int CW = cnt_w(N);
    localparam int NW = N * N;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [CW-1:0]        cnt_d;
    logic                 tready_q;
    logic                 pend_q;
    logic                 err_q;
    logic [N*WIDTH-1:0]   a_vec_q;
    logic [N*N*WIDTH-1:0] b_mat_q;

    logic s_hs;
    logic redirect;
    logic wmode;
    logic last_word;
    logic ser_load;
    logic ser_done;

    assign s_hs = s_axis_tvalid && tready_q;

    // A pending reload seen before the first vector word turns this packet into weights.
    assign redirect  = (state_q == ST_LOAD_A) && pend_q && (cnt_q == '0);
    assign wmode     = (state_q == ST_LOAD_W) || redirect;
    assign last_word = wmode ? (cnt_q == CW'(NW - 1)) : (cnt_q == CW'(N - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (s_hs) begin
            cnt_d = last_word ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_LOAD_W;
            cnt_q    <= '0;
            tready_q <= 1'b1;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
            a_vec_q  <= '0;
            b_mat_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (s_hs && (s_axis_tlast != last_word)) begin
                err_q <= 1'b1;
            end
            if (s_hs && wmode) begin
                b_mat_q[int'(cnt_q) * WIDTH +: WIDTH] <= s_axis_tdata;
            end
            if (s_hs && !wmode) begin
                a_vec_q[int'(cnt_q) * WIDTH +: WIDTH] <= s_axis_tdata;
            end
            if (reload_w) begin
                pend_q <= 1'b1;
            end

            case (state_q)
                ST_LOAD_W: begin
                    if (s_hs && last_word) begin
                        state_q <= ST_LOAD_A;
                    end
                end
                ST_LOAD_A: begin
                    if (redirect) begin
                        pend_q  <= 1'b0;
                        state_q <= (s_hs && last_word) ? ST_LOAD_A : ST_LOAD_W;
                    end else if (s_hs && last_word) begin
                        state_q  <= ST_COMPUTE;
                        tready_q <= 1'b0;
                    end
                end
                ST_COMPUTE: begin
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    // A reload requested during this vector takes effect as it finishes.
                    if (ser_done) begin
                        tready_q <= 1'b1;
                        if (pend_q || reload_w) begin
                            pend_q  <= 1'b0;
                            state_q <= ST_LOAD_W;
                        end else begin
                            state_q <= ST_LOAD_A;
                        end
                    end
                end
                default: begin
                    state_q <= ST_LOAD_W;
                end
            endcase
        end
    end

    assign ser_load = (state_q == ST_COMPUTE);

    mmult_out_ser #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_out_ser (
        .clk_i    (aclk),
        .rst_ni   (aresetn),
        .load_i   (ser_load),
        .y_i      (y_vec),
        .tdata_o  (m_axis_tdata),
        .tvalid_o (m_axis_tvalid),
        .tready_i (m_axis_tready),
        .tlast_o  (m_axis_tlast),
        .done_o   (ser_done)
    );

    assign s_axis_tready = tready_q;
    assign a_vec         = a_vec_q;
    assign b_mat         = b_mat_q;
    assign err_tlast     = err_q;

endmodule

// File: tb/tb_mmult_axis_ctrl.sv
// Scoreboard bench for mmult_axis_ctrl with a behavioural PE grid on the array ports.
module tb_mmult_axis_ctrl;

    localparam int WIDTH = 8;
    localparam int N     = 4;

    logic                 aclk = 1'b0;
    logic                 aresetn;
    logic [WIDTH-1:0]     s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic                 s_axis_tlast;
    logic [WIDTH-1:0]     m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic                 reload_w;
    logic [N*WIDTH-1:0]   a_vec;
    logic [N*N*WIDTH-1:0] b_mat;
    logic [N*WIDTH-1:0]   y_vec;
    logic                 err_tlast;

    int errors = 0;
    int checks = 0;

    int Wm [N][N];
    int va [N];
    logic [WIDTH:0] exp_q [$];

    int   rmode  = 0;
    int   rk     = 0;
    logic mon_en = 1'b0;
    logic hold_pend = 1'b0;
    logic [WIDTH:0] held;
    logic [WIDTH:0] exp_e;

    always #5 aclk = ~aclk;

    mmult_axis_ctrl #(.WIDTH(WIDTH), .N(N)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .reload_w      (reload_w),
        .a_vec         (a_vec),
        .b_mat         (b_mat),
        .y_vec         (y_vec),
        .err_tlast     (err_tlast)
    );

    // Column j of the PE grid: a(i) enters row i, partial sum ripples down the column.
    function automatic logic [WIDTH-1:0] pe_col(input int j, input logic [N*WIDTH-1:0] a,
                                                input logic [N*N*WIDTH-1:0] b);
        logic signed [WIDTH-1:0] psum;
        logic signed [WIDTH-1:0] av;
        logic signed [WIDTH-1:0] bv;
        psum = '0;
        for (int i = 0; i < N; i++) begin
            av   = a[i*WIDTH +: WIDTH];
            bv   = b[(i*N + j)*WIDTH +: WIDTH];
            psum = psum + WIDTH'(av * bv);
        end
        return psum;
    endfunction

    for (genvar gj = 0; gj < N; gj++) begin : g_col
        assign y_vec[gj*WIDTH +: WIDTH] = pe_col(gj, a_vec, b_mat);
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic sync();
        @(posedge aclk);
        #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d, input logic l);
        int t;
        t = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_axis_tready && t < 300) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 300) begin
            checks++;
            errors++;
            $display("FAIL s_tready_timeout: got 0 required 1");
        end
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_weights(input bit pulse, input int tlast_pos);
        if (pulse) begin
            reload_w = 1'b1;
            sync();
            reload_w = 1'b0;
        end
        for (int k = 0; k < N*N; k++) begin
            send_word(WIDTH'(Wm[k / N][k % N]), k == tlast_pos);
        end
    endtask

    // Expected result = plain dot product of the vector with each weight column, mod 2^WIDTH.
    task automatic send_vector();
        int s;
        logic [31:0] sv;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int i = 0; i < N; i++) s += va[i] * Wm[i][j];
            sv = s;
            exp_q.push_back({(j == N - 1), sv[WIDTH-1:0]});
        end
        for (int i = 0; i < N; i++) begin
            send_word(WIDTH'(va[i]), i == N - 1);
        end
    endtask

    task automatic set_vec(input int a0, input int a1, input int a2, input int a3);
        va[0] = a0; va[1] = a1; va[2] = a2; va[3] = a3;
    endtask

    task automatic rand_weights();
        logic [WIDTH-1:0] r;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                r = WIDTH'($urandom_range(0, 255));
                Wm[i][j] = int'($signed(r));
            end
    endtask

    task automatic rand_vec();
        logic [WIDTH-1:0] r;
        for (int i = 0; i < N; i++) begin
            r = WIDTH'($urandom_range(0, 255));
            va[i] = int'($signed(r));
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
        end
        sync();
    endtask

    task automatic wait_tvalid();
        int t;
        t = 0;
        @(negedge aclk);
        while (!m_axis_tvalid && t < 100) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errors++;
            $display("FAIL tvalid_timeout: got 0 required 1");
        end
    endtask

    // Downstream ready driver.
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (rmode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ((rk % 4) == 0) || ((rk % 4) == 3);
                2:       m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b0;
            endcase
            rk++;
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks hold under backpressure.
    initial begin
        forever begin
            @(negedge aclk);
            if (!mon_en || !aresetn) begin
                hold_pend = 1'b0;
            end else begin
                if (hold_pend) begin
                    check("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                          {1'b1, held});
                end
                if (m_axis_tvalid) begin
                    check("s_tready_during_send", s_axis_tready, 1'b0);
                    if (m_axis_tready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_output: got %0h required none", m_axis_tdata);
                        end else begin
                            exp_e = exp_q.pop_front();
                            check("out_word", {m_axis_tlast, m_axis_tdata}, exp_e);
                        end
                        hold_pend = 1'b0;
                    end else begin
                        hold_pend = 1'b1;
                        held      = {m_axis_tlast, m_axis_tdata};
                    end
                end else begin
                    hold_pend = 1'b0;
                end
            end
        end
    end

    initial begin
        aresetn       = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        reload_w      = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_s_tready", s_axis_tready, 1'b1);
        check("rst_m_tvalid", m_axis_tvalid, 1'b0);
        check("rst_m_tlast", m_axis_tlast, 1'b0);
        check("rst_m_tdata", m_axis_tdata, '0);
        check("rst_err", err_tlast, 1'b0);
        check("rst_a_vec", a_vec, '0);
        check("rst_b_mat_nz", (b_mat != '0), 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        mon_en  = 1'b1;
        sync();

        // Identity weights, plus first-output latency.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) Wm[i][j] = (i == j) ? 1 : 0;
        send_weights(1'b0, N*N - 1);
        set_vec(1, 2, 3, 4);
        send_vector();
        @(negedge aclk);
        check("latency_compute_cycle", m_axis_tvalid, 1'b0);
        @(negedge aclk);
        check("latency_first_valid", m_axis_tvalid, 1'b1);
        sync();
        wait_drain();
        check("err_after_identity", err_tlast, 1'b0);

        // b(i,j)=i+j, two vectors on the same weights.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) Wm[i][j] = i + j;
        send_weights(1'b1, N*N - 1);
        set_vec(1, 1, 1, 1);
        send_vector();
        set_vec(2, 0, 0, 0);
        send_vector();
        wait_drain();

        // Wrap-around: every column sum 4*127*127 mod 256.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) Wm[i][j] = 127;
        send_weights(1'b1, N*N - 1);
        set_vec(127, 127, 127, 127);
        send_vector();
        wait_drain();

        // Backpressure pattern 1-0-0-1 across SEND.
        rmode = 1;
        set_vec(-3, 5, 0, 1);
        send_vector();
        rand_vec();
        send_vector();
        wait_drain();
        rmode = 0;

        // Reload requested mid-SEND: vector finishes on old weights, then new weights load.
        rand_vec();
        send_vector();
        wait_tvalid();
        sync();
        reload_w = 1'b1;
        sync();
        reload_w = 1'b0;
        rand_weights();
        send_weights(1'b0, N*N - 1);
        rand_vec();
        send_vector();
        wait_drain();
        check("err_before_tlast_fault", err_tlast, 1'b0);

        // Random traffic with random downstream ready.
        rmode = 2;
        for (int r = 0; r < 3; r++) begin
            rand_weights();
            send_weights(1'b1, N*N - 1);
            for (int v = 0; v < 3; v++) begin
                rand_vec();
                send_vector();
            end
        end
        wait_drain();
        rmode = 0;

        // Misplaced tlast on weight word 10 is sticky.
        rand_weights();
        send_weights(1'b1, 10);
        check("err_tlast_set", err_tlast, 1'b1);
        rand_vec();
        send_vector();
        wait_drain();
        check("err_tlast_sticky", err_tlast, 1'b1);

        // Asynchronous reset in the middle of SEND.
        rmode = 3;
        rand_vec();
        send_vector();
        wait_tvalid();
        mon_en = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_m_tvalid", m_axis_tvalid, 1'b0);
        check("arst_s_tready", s_axis_tready, 1'b1);
        check("arst_b_mat_nz", (b_mat != '0), 1'b0);
        check("arst_a_vec_nz", (a_vec != '0), 1'b0);
        check("arst_err", err_tlast, 1'b0);
        exp_q.delete();
        sync();
        sync();
        aresetn = 1'b1;
        rmode   = 0;
        sync();
        mon_en  = 1'b1;
        rand_weights();
        send_weights(1'b0, N*N - 1);
        rand_vec();
        send_vector();
        wait_drain();
        check("err_after_reset_traffic", err_tlast, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
